mem_bus_arbiter: RTL
====================

# mem_bus_arbiter

Two-port arbiter and access sequencer for the single shared memory bus (Abus, Dbusout, Dbusin, memrd, memwr) between the multicycle CPU core and the `memory` model. Master 0 is the CPU core; master 1 is a secondary requester such as a program loader or DMA engine. The block grants the bus round-robin and runs each read or write for a fixed number of cycles. It returns read data with a single-cycle acknowledge.

## Interface
Parameters:
- AW, 16, address width
- DW, 16, data width
- MEM_LAT, 2, cycles memrd/memwr are held per access (legal range 1..15)

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - clk  in  1  system clock; all state changes on the rising edge
  - rst  in  1  synchronous reset, active-high
- Master 0 (CPU core):
  - m0_req  in  1  access request, level
  - m0_wr  in  1  1 = write, 0 = read
  - m0_addr  in  AW  access address
  - m0_wdata  in  DW  write data
  - m0_ack  out  1  one-cycle completion pulse
  - m0_rdata  out  DW  read data, registered
- Master 1 (secondary requester): m1_req, m1_wr, m1_addr, m1_wdata, m1_ack, m1_rdata, same widths and meaning as master 0.
- Memory side:
  - Abus  out  AW  memory address
  - Dbusout  out  DW  write data to memory
  - Dbusin  in  DW  read data from memory
  - memrd  out  1  read strobe
  - memwr  out  1  write strobe
- Status:
  - busy  out  1  high in ACCESS and ACK

## Operation
- FSM states: IDLE, ACCESS, ACK. All outputs are registered.
- IDLE: requests are sampled on each edge.
  - If exactly one master requests, that master is granted.
  - If both request, the master not granted last is granted. The `last` pointer resets to 1, so m0 wins the first tie.
  - On grant:
    - latch owner, wr, addr and wdata
    - load cnt = MEM_LAT-1
    - go to ACCESS
- ACCESS:
  - Abus = latched addr.
  - memrd = ~wr and memwr = wr. The two strobes are never high together.
  - Dbusout = wdata on a write, 0 on a read.
  - cnt decrements each cycle.
  - At the edge where cnt==0: on a read, Dbusin is captured into the owner's rdata; then go to ACK.
- ACK:
  - Owner's ack = 1 for exactly one cycle.
  - memrd, memwr, Abus and Dbusout are all 0.
  - `last` is updated to the owner.
  - Return to IDLE.
- Master inputs are ignored outside IDLE. Dropping req during ACCESS does not cancel the access; the ack is still issued.
- A req still high in the IDLE cycle after ack counts as a new request. Requesters drop req in the ack cycle if no further access is wanted.
- m0_rdata and m1_rdata hold their value until that master's next read completes. Writes leave rdata unchanged.
- At most one ack is high in any cycle.

## Timing
- Reset values:
  - state IDLE, last = 1, cnt = 0
  - m0_ack, m1_ack, m0_rdata, m1_rdata = 0
  - Abus, Dbusout, memrd, memwr, busy = 0
- Reset mid-operation:
  - the cycle after rst is sampled, all outputs take their reset values
  - no ack is issued
  - the in-flight access is dropped
- Latency, with req sampled at edge T in IDLE:
  - strobes high in cycles T+1 .. T+MEM_LAT
  - ack and valid rdata in cycle T+MEM_LAT+1
  - IDLE again at T+MEM_LAT+2
- Throughput: one access per MEM_LAT+2 cycles. With both masters requesting continuously, grants strictly alternate.
- Dbusin is sampled only on the last ACCESS edge. The memory must present read data within MEM_LAT cycles of memrd rising.

## Test plan
- Reset: hold rst 2 cycles with both reqs high → all outputs 0 throughout, no strobe; first grant goes to m0 after rst falls.
- Single read, MEM_LAT=2: m0 reads 0x0010, memory returns 0xBEEF → Abus=0x0010 and memrd=1 for 2 cycles, m0_ack pulses on the 3rd cycle with m0_rdata=0xBEEF, m1_ack stays 0.
- Single write: m1 writes 0x1234 to 0x0020 → memwr=1 for 2 cycles with Abus=0x0020 and Dbusout=0x1234, memrd stays 0, m1_ack pulses once, m1_rdata unchanged.
- Contention: both reqs held high for 16 cycles → grant order m0, m1, m0, m1, with acks 4 cycles apart and memrd/memwr never both 1.
- Reset mid-access: assert rst in the 1st ACCESS cycle → memrd low next cycle, no ack, busy=0; a following tie is granted to m0.
- Withdrawn request: m0 read starts, then m0_req drops during ACCESS → the access completes and m0_ack still pulses with the captured data.

Source files
------------

// File: rtl/mem_bus_arbiter_if.sv
// Shared-memory bus bundle for mem_bus_arbiter: two requesting masters,
// the memory-side strobes and the busy status. The slave modport is the
// arbiter's view; the master modport is the view of whatever drives it.
interface mem_bus_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic          m0_req;
    logic          m0_wr;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata;
    logic          m0_ack;
    logic [DW-1:0] m0_rdata;

    logic          m1_req;
    logic          m1_wr;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata;
    logic          m1_ack;
    logic [DW-1:0] m1_rdata;

    logic [AW-1:0] Abus;
    logic [DW-1:0] Dbusout;
    logic [DW-1:0] Dbusin;
    logic          memrd;
    logic          memwr;
    logic          busy;

    modport slave (
        input  m0_req, m0_wr, m0_addr, m0_wdata,
        input  m1_req, m1_wr, m1_addr, m1_wdata,
        input  Dbusin,
        output m0_ack, m0_rdata, m1_ack, m1_rdata,
        output Abus, Dbusout, memrd, memwr, busy
    );

    modport master (
        output m0_req, m0_wr, m0_addr, m0_wdata,
        output m1_req, m1_wr, m1_addr, m1_wdata,
        output Dbusin,
        input  m0_ack, m0_rdata, m1_ack, m1_rdata,
        input  Abus, Dbusout, memrd, memwr, busy
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter and fixed-length access sequencer for the single
// shared memory bus. Each granted access holds its strobe for MEM_LAT
// cycles, then the owner gets a one-cycle ack with registered read data.
module mem_bus_arbiter #(
    parameter int AW      = 16,
    parameter int DW      = 16,
    parameter int MEM_LAT = 2
) (
    input  logic               clk,
    input  logic               rst,
    mem_bus_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

    state_t        state_q, state_d;
    logic          last_q, last_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          owner_q, owner_d;
    logic          wr_q, wr_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;

    logic          m0_ack_q, m0_ack_d;
    logic          m1_ack_q, m1_ack_d;
    logic [DW-1:0] m0_rdata_q, m0_rdata_d;
    logic [DW-1:0] m1_rdata_q, m1_rdata_d;
    logic [AW-1:0] abus_q, abus_d;
    logic [DW-1:0] dbusout_q, dbusout_d;
    logic          memrd_q, memrd_d;
    logic          memwr_q, memwr_d;
    logic          busy_q, busy_d;

    logic          req_any;
    logic          grant_m1;
    logic          sel_wr;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    // Pick the winner among current requests; on a tie the master not served last wins.
    always_comb begin
        req_any   = bus.m0_req | bus.m1_req;
        grant_m1  = (bus.m0_req & bus.m1_req) ? ~last_q : bus.m1_req;
        sel_wr    = grant_m1 ? bus.m1_wr    : bus.m0_wr;
        sel_addr  = grant_m1 ? bus.m1_addr  : bus.m0_addr;
        sel_wdata = grant_m1 ? bus.m1_wdata : bus.m0_wdata;
    end

    // Next-state and next-output logic for the IDLE/ACCESS/ACK sequence.
    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        owner_d    = owner_q;
        wr_d       = wr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        m0_ack_d   = 1'b0;
        m1_ack_d   = 1'b0;
        m0_rdata_d = m0_rdata_q;
        m1_rdata_d = m1_rdata_q;
        abus_d     = abus_q;
        dbusout_d  = dbusout_q;
        memrd_d    = memrd_q;
        memwr_d    = memwr_q;
        busy_d     = busy_q;

        case (state_q)
            IDLE: begin
                if (req_any) begin
                    owner_d   = grant_m1;
                    wr_d      = sel_wr;
                    addr_d    = sel_addr;
                    wdata_d   = sel_wdata;
                    cnt_d     = CNT_INIT;
                    abus_d    = sel_addr;
                    dbusout_d = sel_wr ? sel_wdata : '0;
                    memrd_d   = ~sel_wr;
                    memwr_d   = sel_wr;
                    busy_d    = 1'b1;
                    state_d   = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    if (!wr_q) begin
                        if (owner_q) m1_rdata_d = bus.Dbusin;
                        else         m0_rdata_d = bus.Dbusin;
                    end
                    m0_ack_d  = ~owner_q;
                    m1_ack_d  = owner_q;
                    abus_d    = '0;
                    dbusout_d = '0;
                    memrd_d   = 1'b0;
                    memwr_d   = 1'b0;
                    state_d   = ACK;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ACK: begin
                last_d  = owner_q;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // All state and outputs are registered; reset drops any in-flight access.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            last_q     <= 1'b1;
            cnt_q      <= 4'd0;
            owner_q    <= 1'b0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            m0_ack_q   <= 1'b0;
            m1_ack_q   <= 1'b0;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
            abus_q     <= '0;
            dbusout_q  <= '0;
            memrd_q    <= 1'b0;
            memwr_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            owner_q    <= owner_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            m0_ack_q   <= m0_ack_d;
            m1_ack_q   <= m1_ack_d;
            m0_rdata_q <= m0_rdata_d;
            m1_rdata_q <= m1_rdata_d;
            abus_q     <= abus_d;
            dbusout_q  <= dbusout_d;
            memrd_q    <= memrd_d;
            memwr_q    <= memwr_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.m0_ack   = m0_ack_q;
    assign bus.m1_ack   = m1_ack_q;
    assign bus.m0_rdata = m0_rdata_q;
    assign bus.m1_rdata = m1_rdata_q;
    assign bus.Abus     = abus_q;
    assign bus.Dbusout  = dbusout_q;
    assign bus.memrd    = memrd_q;
    assign bus.memwr    = memwr_q;
    assign bus.busy     = busy_q;
endmodule
